// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer that feeds an external ALU and retires its results.
// Optional INSTR_COUNTER_EN adds a free-running retired-instruction counter output.
module alu_sequencer #(
    parameter int          PC_W     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            alu_go,
    output logic [5:0]      instr,
    output logic [31:0]     A,
    output logic [31:0]     B,
    output logic [31:0]     reg8,
    output logic [15:0]     value,
    output logic            highlow,
    output logic            F1,
    output logic            F2,
    input  logic [31:0]     C,
    input  logic            F3,
    input  logic            addrch,
    input  logic [31:0]     naddr,
    output logic            halted
`ifdef INSTR_COUNTER_EN
    , output logic [31:0]   retired
`endif
);

    // state  | meaning
    // FETCH  | imem_req held until imem_ack, word latched into ir
    // DECODE | operands driven from ir and register file
    // EXEC   | alu_go high for one cycle, ALU results captured
    // WB     | register/flag write, pc update
    // HALT   | op 63 retired, everything frozen until reset
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_HALT = 6'd63;

    state_t            state;
    state_t            state_next;
    logic              req_q;
    logic [31:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [31:0]       regs [16];
    logic              f1_q;
    logic              f2_q;

    logic [31:0]       c_q;
    logic              f3_q;
    logic              addrch_q;
    logic [PC_W-1:0]   naddr_q;

    logic [5:0]        op;
    logic [3:0]        rd;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic              fetch_take;
    logic              wr_reg;
    logic              wr_flag;

    // Only the low PC_W bits of the branch target address the instruction memory.
    logic              unused_naddr_hi;
    assign unused_naddr_hi = ^naddr[31:PC_W];

    assign op = ir[31:26];
    assign rd = ir[25:22];
    assign ra = ir[21:18];
    assign rb = ir[17:14];

    assign fetch_take = (state == S_FETCH) && req_q && imem_ack;
    assign wr_reg     = (state == S_WB) && (op <= 6'd7);
    assign wr_flag    = (state == S_WB) && (op >= 6'd8) && (op <= 6'd13);

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (fetch_take) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = (op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // req_q is registered so the request appears one cycle after reset release
    // and drops in the same cycle the word is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            req_q <= 1'b0;
        end else begin
            state <= state_next;
            req_q <= (state_next == S_FETCH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir <= '0;
        end else if (fetch_take) begin
            ir <= imem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            c_q      <= '0;
            f3_q     <= 1'b0;
            addrch_q <= 1'b0;
            naddr_q  <= '0;
        end else if (state == S_EXEC) begin
            c_q      <= C;
            f3_q     <= F3;
            addrch_q <= addrch;
            naddr_q  <= naddr[PC_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_reg) begin
            regs[rd] <= c_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            f1_q <= 1'b0;
            f2_q <= 1'b0;
        end else if (wr_flag) begin
            f2_q <= f1_q;
            f1_q <= f3_q;
        end
    end

    // The halt instruction freezes pc at its own address, even if addrch was set.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= PC_W'(RESET_PC);
        end else if ((state == S_WB) && (op != OP_HALT)) begin
            pc <= addrch_q ? naddr_q : pc + 1'b1;
        end
    end

`ifdef INSTR_COUNTER_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            retired <= '0;
        end else if (state == S_WB) begin
            retired <= retired + 32'd1;
        end
    end
`endif

    assign imem_req  = req_q;
    assign imem_addr = pc;
    assign alu_go    = (state == S_EXEC);
    assign halted    = (state == S_HALT);
    assign F1        = f1_q;
    assign F2        = f2_q;

    assign instr   = op;
    assign A       = ((op == 6'd5) || (op == 6'd6)) ? regs[rd] : regs[ra];
    assign B       = regs[rb];
    assign reg8    = regs[8];
    assign value   = ir[15:0];
    assign highlow = (op == 6'd6);

endmodule
